// File: rtl/mult_pkg.sv
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared constants and sign encoding for the signed multiplier
//            datapath (operand split front-end and output sign-apply stage).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int MULT_W = 32;

  // Most negative operand, -2^(MULT_W-1); its magnitude is exactly 2^(MULT_W-1).
  localparam logic [MULT_W-1:0] MULT_MIN = {1'b1, {(MULT_W-1){1'b0}}};

  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } sign_e;

endpackage

`default_nettype wire

// File: rtl/abs_conv.sv
// ============================================================================
// Module   : abs_conv
// Purpose  : Combinational two's-complement to unsigned magnitude, sign and
//            most-negative-value detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module abs_conv
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic [W-1:0] val,
  output logic [W-1:0] mag,
  output logic         sign,
  output logic         is_min
);

  localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

  sign_e w_sign;

  assign w_sign = val[W-1] ? SIGN_NEG : SIGN_POS;
  assign sign   = w_sign;

  // -2^(W-1) negates to itself, which reads correctly as 2^(W-1) unsigned.
  assign mag    = (w_sign == SIGN_NEG) ? (~val + W'(1)) : val;
  assign is_min = (val == c_min);

endmodule

`default_nettype wire

// File: rtl/sign_split.sv
// ============================================================================
// Module   : sign_split
// Purpose  : Two-stage valid/ready front-end splitting signed operands into
//            magnitudes, operand signs and product sign.
//            Optional: SIGN_SPLIT_ZERO_SIGN_EN forces sp=0 for a zero operand.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_split
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] as_mag,
  output logic [W-1:0] bs_mag,
  output logic         sa,
  output logic         sb,
  output logic         sp,
  output logic         min_flag
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_s1_valid;
  logic         r_s2_valid;
  logic [W-1:0] r_as_mag;
  logic [W-1:0] r_bs_mag;
  logic         r_sa;
  logic         r_sb;
  logic         r_sp;
  logic         r_min_flag;

  logic         w_adv1;
  logic         w_adv2;
  logic [W-1:0] w_as_mag;
  logic [W-1:0] w_bs_mag;
  logic         w_sa;
  logic         w_sb;
  logic         w_sp;
  logic         w_a_min;
  logic         w_b_min;

  assign w_adv2   = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_adv1   = in_valid & in_ready;

  abs_conv #(.W(W)) u_abs_a (
    .val    (r_a),
    .mag    (w_as_mag),
    .sign   (w_sa),
    .is_min (w_a_min)
  );

  abs_conv #(.W(W)) u_abs_b (
    .val    (r_b),
    .mag    (w_bs_mag),
    .sign   (w_sb),
    .is_min (w_b_min)
  );

`ifdef SIGN_SPLIT_ZERO_SIGN_EN
  // A zero product must never be negated downstream.
  assign w_sp = (w_sa ^ w_sb) & ~((r_a == '0) | (r_b == '0));
`else
  assign w_sp = w_sa ^ w_sb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_as_mag   <= '0;
      r_bs_mag   <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_sp       <= 1'b0;
      r_min_flag <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_a        <= a;
        r_b        <= b;
        r_s1_valid <= 1'b1;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end

      // Output registers only load on advance, so they hold under backpressure.
      if (w_adv2) begin
        r_as_mag   <= w_as_mag;
        r_bs_mag   <= w_bs_mag;
        r_sa       <= w_sa;
        r_sb       <= w_sb;
        r_sp       <= w_sp;
        r_min_flag <= w_a_min | w_b_min;
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign as_mag    = r_as_mag;
  assign bs_mag    = r_bs_mag;
  assign sa        = r_sa;
  assign sb        = r_sb;
  assign sp        = r_sp;
  assign min_flag  = r_min_flag;

endmodule

`default_nettype wire

// File: tb/tb_sign_split.sv
// ============================================================================
// Module   : tb_sign_split
// Purpose  : Directed self-checking bench for sign_split (W=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sign_split;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] as_mag;
  logic [W-1:0] bs_mag;
  logic         sa;
  logic         sb;
  logic         sp;
  logic         min_flag;

  int n_checks = 0;
  int n_fail   = 0;

  sign_split #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .as_mag    (as_mag),
    .bs_mag    (bs_mag),
    .sa        (sa),
    .sb        (sb),
    .sp        (sp),
    .min_flag  (min_flag)
  );

  always #5 clk = ~clk;

  // Hand-computed vectors: operands, magnitudes, operand signs, product sign.
  logic [W-1:0] tab_a   [8] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0064, 32'hFFFF_FFFB,
                                32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'h0000_3039};
  logic [W-1:0] tab_b   [8] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FF9C, 32'hFFFF_FFFA,
                                32'h0000_0007, 32'h8000_0001, 32'h0000_0010, 32'hFFFF_CFC7};
  logic [W-1:0] tab_am  [8] = '{32'd1, 32'd2, 32'd100, 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd16, 32'd12345};
  logic [W-1:0] tab_bm  [8] = '{32'd1, 32'd3, 32'd100, 32'd6, 32'd7, 32'h7FFF_FFFF, 32'd16, 32'd12345};
  logic         tab_sa  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         tab_sb  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic         tab_sp  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  function automatic logic [67:0] exp_vec(input int i);
    return {tab_am[i], tab_bm[i], tab_sa[i], tab_sb[i], tab_sp[i], 1'b0};
  endfunction

  function automatic logic [67:0] act_vec();
    return {as_mag, bs_mag, sa, sb, sp, min_flag};
  endfunction

  // Offer one pair with out_ready=1 and wait for its result; lat counts negedges.
  task automatic send_wait(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           output bit ok, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid/in_ready got %b required 01", {out_valid, in_ready});
    end
    n_checks++;
    if (act_vec() !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h required 0", act_vec());
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    send_wait(32'd5, 32'hFFFF_FFFD, ok, lat);
    n_checks++;
    if (!ok || lat != 2) begin
      n_fail++;
      $display("FAIL basic_latency: got valid=%0d after %0d cycles required 2", ok, lat);
    end
    n_checks++;
    if (act_vec() !== {32'd5, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_5_m3: got %h required %h", act_vec(),
               {32'd5, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_min();
    bit ok;
    int lat;
    send_wait(32'h8000_0000, 32'hFFFF_FFFF, ok, lat);
    n_checks++;
    if (!ok || act_vec() !== {32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL min_operand: got valid=%0d %h required %h", ok, act_vec(),
               {32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_zero_sign();
    bit ok;
    int lat;
    logic exp_sp;
`ifdef SIGN_SPLIT_ZERO_SIGN_EN
    exp_sp = 1'b0;
`else
    exp_sp = 1'b1;
`endif
    send_wait(32'd0, 32'hFFFF_FFF9, ok, lat);
    n_checks++;
    if (!ok || act_vec() !== {32'd0, 32'd7, 1'b0, 1'b1, exp_sp, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_sign: got valid=%0d %h required %h", ok, act_vec(),
               {32'd0, 32'd7, 1'b0, 1'b1, exp_sp, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (k < 8) begin
        in_valid = 1'b1;
        a = tab_a[k];
        b = tab_b[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready[%0d]: got %b required 1", k, in_ready);
        end
      end
      n_checks++;
      if (out_valid !== (k >= 2 && k <= 9)) begin
        n_fail++;
        $display("FAIL b2b_out_valid[%0d]: got %b required %b", k, out_valid, (k >= 2 && k <= 9));
      end else if (k >= 2 && k <= 9) begin
        n_checks++;
        if (act_vec() !== exp_vec(k - 2)) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h required %h", k - 2, act_vec(), exp_vec(k - 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int rcv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = tab_a[idx];
      b = tab_b[idx];
      #1;
      if (in_ready) idx++;
      if (c >= 2) begin
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10 || act_vec() !== exp_vec(0)) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got ov/ir=%b %h required 10 %h",
                   c, {out_valid, in_ready}, act_vec(), exp_vec(0));
        end
      end
    end
    n_checks++;
    if (idx != 2) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d required 2", idx);
    end
    for (int c = 0; c < 20 && (rcv < 4 || idx < 4); c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 4);
      if (idx < 4) begin
        a = tab_a[idx];
        b = tab_b[idx];
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        n_checks++;
        if (rcv >= 4 || act_vec() !== exp_vec(rcv)) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: got %h required %h", rcv, act_vec(), exp_vec(rcv & 3));
        end
        rcv++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (rcv != 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required 4", rcv);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_extra: got out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = tab_a[k + 4];
      b = tab_b[k + 4];
    end
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_full: got ov/ir=%b required 10", {out_valid, in_ready});
    end
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01 || act_vec() !== 68'h0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got ov/ir=%b %h required 01 0", {out_valid, in_ready}, act_vec());
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale[%0d]: got out_valid %b required 0", k, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min();
    test_zero_sign();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sign_split.md
Name: sign_split

Overview:
- Front-end of the signed multiplier datapath, and the inverse of the output sign-apply stage.
- Accepts two W-bit two's-complement operands and emits their unsigned magnitudes, the individual operand signs and the product sign.
- The unsigned core multiplies the magnitudes; the product sign is then re-applied downstream.
- Two-stage pipeline with valid/ready handshake on both sides, so it can stall under backpressure from the multiplier.

Parameters:
W, 32, operand width in bits (magnitude outputs also W bits)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block can accept operand pair this cycle
a  input  W  signed operand A, two's complement
b  input  W  signed operand B, two's complement
out_valid  output  1  outputs below valid
out_ready  input  1  consumer accepts outputs this cycle
as_mag  output  W  |a| as unsigned
bs_mag  output  W  |b| as unsigned
sa  output  1  sign of a (a[W-1])
sb  output  1  sign of b (b[W-1])
sp  output  1  product sign
min_flag  output  1  a or b equalled -2^(W-1)

Behaviour:
- Reset (rst=1 at clk edge):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - as_mag, bs_mag, sa, sb, sp and min_flag all 0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards all in-flight data; no output is produced for it.
- Stage 1 (capture):
  - Registers a, b and s1_valid.
  - adv1 = in_valid & in_ready.
  - in_ready = !s1_valid | adv2 (combinational path from out_ready).
- Stage 2 (convert):
  - adv2 = s1_valid & (!s2_valid | out_ready).
  - On adv2 it registers:
    - as_mag = a[W-1] ? (~a + 1) : a, truncated to W bits unsigned; likewise bs_mag.
    - sa = a[W-1], sb = b[W-1], sp = sa ^ sb.
    - min_flag = (a == 1 followed by W-1 zeros) | (same for b).
- Magnitude width: -2^(W-1) yields as_mag = 2^(W-1), which is representable as unsigned W bits. No saturation; min_flag is informational only.
- out_valid = s2_valid.
  - s2_valid is set on adv2.
  - It is cleared when out_ready=1 and no adv2 occurs in the same cycle.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput is 1 pair/cycle when out_ready is held at 1.
- Full: s1_valid=1, s2_valid=1, out_ready=0 gives in_ready=0; a/b are ignored.
- Simultaneous events:
  - Output handshake, s1→s2 advance and input capture may all occur in the same cycle with no bubble.
  - When s1 is empty and s2 drains, s1_valid clears unless a new input is captured.
- in_valid while in_ready=0: no capture. The producer must hold a/b.
- No combinational path from a/b to any output.

Optional Feature:
- Macro: SIGN_SPLIT_ZERO_SIGN_EN
- Defined: sp is forced to 0 when a==0 or b==0, so the downstream sign-apply never negates a zero product. sa and sb are unchanged.
- Undefined: sp = sa ^ sb always.
- Port list is identical in both builds.

Decomposition:
- Shared package mult_pkg holds:
  - the W default (MULT_W=32);
  - the operand-min constant, function of W;
  - the sign-pair encoding (SIGN_POS=0, SIGN_NEG=1) shared with the output sign-apply stage.
- One natural sub-module: abs_conv (combinational W-bit two's-complement to magnitude + sign + is_min), instantiated twice in stage 2.
- Pipeline control stays in sign_split.

Test Plan:
- a=5, b=-3, out_ready=1 → 2 cycles later: as_mag=5, bs_mag=3, sa=0, sb=1, sp=1, min_flag=0.
- a=-2^31, b=-1 (W=32) → as_mag=0x80000000, bs_mag=1, sa=1, sb=1, sp=0, min_flag=1.
- Back-to-back 8 pairs with out_ready=1 → 8 consecutive out_valid cycles, in order, no bubbles.
- Hold out_ready=0 with in_valid=1 continuously:
  - in_ready drops after 2 accepts and outputs stay stable.
  - When out_ready is released, all pairs emerge in order with none lost or duplicated.
- a=0, b=-7:
  - sp=0 with SIGN_SPLIT_ZERO_SIGN_EN defined.
  - sp=1 with it undefined.
  - In both builds as_mag=0, bs_mag=7.
- Assert rst for 1 cycle while both stages are full → next cycle out_valid=0, in_ready=1, all outputs 0, and no stale data emitted afterwards.
